// File: rtl/hci_core_load_store_splitter_pkg.sv
// Shared types and defaults for the HCI-core load/store splitter.
// The route bit records which downstream path owns each granted transaction.
package hci_core_load_store_splitter_pkg;

    localparam int unsigned DEFAULT_DW = 32;
    localparam int unsigned DEFAULT_AW = 32;
    localparam int unsigned DEFAULT_BW = 8;
    localparam int unsigned DEFAULT_WW = 32;
    localparam int unsigned DEFAULT_UW = 1;

    typedef enum logic {
        HCI_LS_LOAD  = 1'b0,
        HCI_LS_STORE = 1'b1
    } hci_ls_route_e;

    // Response entry is {r_data, r_opc, r_user}.
    function automatic int unsigned hci_ls_resp_w(input int unsigned dw, input int unsigned uw);
        return dw + 1 + uw;
    endfunction

endpackage

// File: rtl/hci_core_load_store_splitter_fifo.sv
// Flop-based FIFO with wrap-bit pointers; head is visible combinationally on o_rdata.
// Pushes while full and pops while empty are dropped; clear_i empties it synchronously.
module hci_ls_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW:0]                 r_wptr;
    logic [PW:0]                 r_rptr;
    logic                        w_push;
    logic                        w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign o_rdata = r_mem[r_rptr[PW-1:0]];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PW-1:0]] <= i_wdata;
                r_wptr                <= r_wptr + (PW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/hci_core_load_store_splitter.sv
// Splits one HCI-core initiator onto separate load (wen=1) and store (wen=0) masters and
// returns responses upstream strictly in grant order, buffering whichever path runs ahead.
module hci_core_load_store_splitter
    import hci_core_load_store_splitter_pkg::*;
#(
    parameter int unsigned DW            = DEFAULT_DW,
    parameter int unsigned AW            = DEFAULT_AW,
    parameter int unsigned BW            = DEFAULT_BW,
    parameter int unsigned WW            = DEFAULT_WW,
    parameter int unsigned OW            = 1,
    parameter int unsigned UW            = DEFAULT_UW,
    parameter int unsigned N_OUTSTANDING = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    // upstream initiator
    input  logic                     i_in_req,
    output logic                     o_in_gnt,
    input  logic [AW-1:0]            i_in_add,
    input  logic                     i_in_wen,
    input  logic [DW/BW-1:0]         i_in_be,
    input  logic [DW-1:0]            i_in_data,
    input  logic [OW*(DW/WW)-1:0]    i_in_boffs,
    input  logic [UW-1:0]            i_in_user,
    input  logic                     i_in_lrdy,
    output logic                     o_in_r_valid,
    output logic [DW-1:0]            o_in_r_data,
    output logic                     o_in_r_opc,
    output logic [UW-1:0]            o_in_r_user,
    // load master
    output logic                     o_ld_req,
    input  logic                     i_ld_gnt,
    output logic [AW-1:0]            o_ld_add,
    output logic                     o_ld_wen,
    output logic [DW/BW-1:0]         o_ld_be,
    output logic [DW-1:0]            o_ld_data,
    output logic [OW*(DW/WW)-1:0]    o_ld_boffs,
    output logic [UW-1:0]            o_ld_user,
    output logic                     o_ld_lrdy,
    input  logic                     i_ld_r_valid,
    input  logic [DW-1:0]            i_ld_r_data,
    input  logic                     i_ld_r_opc,
    input  logic [UW-1:0]            i_ld_r_user,
    // store master
    output logic                     o_st_req,
    input  logic                     i_st_gnt,
    output logic [AW-1:0]            o_st_add,
    output logic                     o_st_wen,
    output logic [DW/BW-1:0]         o_st_be,
    output logic [DW-1:0]            o_st_data,
    output logic [OW*(DW/WW)-1:0]    o_st_boffs,
    output logic [UW-1:0]            o_st_user,
    output logic                     o_st_lrdy,
    input  logic                     i_st_r_valid,
    input  logic [DW-1:0]            i_st_r_data,
    input  logic                     i_st_r_opc,
    input  logic [UW-1:0]            i_st_r_user,
    // granted-but-unanswered transactions
    output logic [$clog2(N_OUTSTANDING):0] o_outstanding
);

    localparam int unsigned CW = $clog2(N_OUTSTANDING) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned RW = hci_ls_resp_w(DW, UW);
    localparam logic [CW-1:0] FULL_CNT = CW'(N_OUTSTANDING);

    hci_ls_route_e          w_route;
    logic                   w_full;
    logic                   w_open;
    logic                   w_sel_gnt;
    logic                   w_grant;
    logic                   w_pop;
    logic [0:0]             w_route_rdata;
    logic                   w_head_idx;
    logic                   w_route_full;
    logic                   w_route_empty;
    logic [1:0]             w_rv;
    logic [1:0][RW-1:0]     w_resp_wdata;
    logic [1:0][RW-1:0]     w_resp_rdata;
    logic [1:0]             w_resp_full;
    logic [1:0]             w_resp_empty;
    logic [CW-1:0]          r_cnt;

    // ---------------- request path (combinational) ----------------
    assign w_route   = i_in_wen ? HCI_LS_LOAD : HCI_LS_STORE;
    assign w_full    = (r_cnt == FULL_CNT);
    assign w_open    = ~w_full & ~clear_i;
    assign w_sel_gnt = (w_route == HCI_LS_LOAD) ? i_ld_gnt : i_st_gnt;
    assign o_in_gnt  = i_in_req & w_sel_gnt & w_open;
    assign w_grant   = o_in_gnt;

    assign o_ld_req   = i_in_req & (w_route == HCI_LS_LOAD) & w_open;
    assign o_st_req   = i_in_req & (w_route == HCI_LS_STORE) & w_open;
    assign o_ld_add   = i_in_add;
    assign o_ld_wen   = i_in_wen;
    assign o_ld_be    = i_in_be;
    assign o_ld_data  = i_in_data;
    assign o_ld_boffs = i_in_boffs;
    assign o_ld_user  = i_in_user;
    assign o_st_add   = i_in_add;
    assign o_st_wen   = i_in_wen;
    assign o_st_be    = i_in_be;
    assign o_st_data  = i_in_data;
    assign o_st_boffs = i_in_boffs;
    assign o_st_user  = i_in_user;
    // The outstanding bound guarantees response buffer space.
    assign o_ld_lrdy  = 1'b1;
    assign o_st_lrdy  = 1'b1;

    // ---------------- grant-order bookkeeping ----------------
    hci_ls_fifo #(.WIDTH(1), .DEPTH(N_OUTSTANDING)) i_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .i_push  (w_grant),
        .i_wdata (w_route),
        .i_pop   (w_pop),
        .o_rdata (w_route_rdata),
        .o_full  (w_route_full),
        .o_empty (w_route_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (w_grant & ~w_pop) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (~w_grant & w_pop) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_outstanding = r_cnt;

    // ---------------- per-path response capture ----------------
    assign w_rv         = {i_st_r_valid, i_ld_r_valid};
    assign w_resp_wdata = {{i_st_r_data, i_st_r_opc, i_st_r_user},
                           {i_ld_r_data, i_ld_r_opc, i_ld_r_user}};

    for (genvar p = 0; p < 2; p++) begin : g_path
        logic [CW-1:0] r_await;
        logic [SW-1:0] r_stale;
        logic          w_stale_hit;
        logic          w_take;
        logic          w_path_gnt;

        // Responses owed to transactions dropped by clear_i arrive first; swallow them.
        assign w_stale_hit = (r_stale != '0);
        assign w_take      = w_rv[p] & ~w_stale_hit & ~clear_i;
        assign w_path_gnt  = w_grant & (w_route == hci_ls_route_e'(1'(p)));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_await <= '0;
                r_stale <= '0;
            end else if (clear_i) begin
                r_await <= '0;
                r_stale <= r_stale + SW'(r_await) - SW'(w_rv[p]);
            end else begin
                r_await <= r_await + CW'(w_path_gnt) - CW'(w_rv[p] & ~w_stale_hit);
                if (w_rv[p] & w_stale_hit) begin
                    r_stale <= r_stale - SW'(1);
                end
            end
        end

        hci_ls_fifo #(.WIDTH(RW), .DEPTH(N_OUTSTANDING)) i_resp_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .i_push  (w_take),
            .i_wdata (w_resp_wdata[p]),
            .i_pop   (w_pop & (w_head_idx == 1'(p))),
            .o_rdata (w_resp_rdata[p]),
            .o_full  (w_resp_full[p]),
            .o_empty (w_resp_empty[p])
        );

        a_rv_owed: assert property (@(posedge clk_i) disable iff (!rst_ni)
            w_rv[p] |-> (r_await != '0 || r_stale != '0));
        a_resp_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
            w_take |-> !w_resp_full[p]);
    end

    a_route_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_grant |-> !w_route_full);

    // ---------------- in-order response return ----------------
    assign w_head_idx   = w_route_rdata[0];
    assign o_in_r_valid = ~w_route_empty & ~w_resp_empty[w_head_idx];
    assign w_pop        = o_in_r_valid & i_in_lrdy & ~clear_i;
    assign {o_in_r_data, o_in_r_opc, o_in_r_user} = o_in_r_valid ? w_resp_rdata[w_head_idx] : '0;

endmodule

// File: tb/tb_hci_core_load_store_splitter.sv
// Randomized bench for the load/store splitter: downstream paths are modelled as in-order
// queues with per-path latency, and a grant-order scoreboard predicts every upstream output.
module tb_hci_core_load_store_splitter;

    localparam int DW = 32, AW = 32, BW = 8, WW = 32, OW = 1, UW = 2, N = 4;
    localparam int BEW = DW / BW, BOW = OW * (DW / WW), CW = $clog2(N) + 1;

    logic clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
    logic i_in_req, o_in_gnt, i_in_wen, i_in_lrdy, o_in_r_valid, o_in_r_opc;
    logic [AW-1:0] i_in_add, o_ld_add, o_st_add;
    logic [BEW-1:0] i_in_be, o_ld_be, o_st_be;
    logic [DW-1:0] i_in_data, o_ld_data, o_st_data, o_in_r_data, i_ld_r_data, i_st_r_data;
    logic [BOW-1:0] i_in_boffs, o_ld_boffs, o_st_boffs;
    logic [UW-1:0] i_in_user, o_ld_user, o_st_user, o_in_r_user, i_ld_r_user, i_st_r_user;
    logic o_ld_req, i_ld_gnt, o_ld_wen, o_ld_lrdy, i_ld_r_valid, i_ld_r_opc;
    logic o_st_req, i_st_gnt, o_st_wen, o_st_lrdy, i_st_r_valid, i_st_r_opc;
    logic [CW-1:0] o_outstanding;

    always #5 clk_i = ~clk_i;

    hci_core_load_store_splitter #(.DW(DW), .AW(AW), .BW(BW), .WW(WW), .OW(OW), .UW(UW),
                                   .N_OUTSTANDING(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .i_in_req(i_in_req), .o_in_gnt(o_in_gnt), .i_in_add(i_in_add), .i_in_wen(i_in_wen),
        .i_in_be(i_in_be), .i_in_data(i_in_data), .i_in_boffs(i_in_boffs), .i_in_user(i_in_user),
        .i_in_lrdy(i_in_lrdy), .o_in_r_valid(o_in_r_valid), .o_in_r_data(o_in_r_data),
        .o_in_r_opc(o_in_r_opc), .o_in_r_user(o_in_r_user),
        .o_ld_req(o_ld_req), .i_ld_gnt(i_ld_gnt), .o_ld_add(o_ld_add), .o_ld_wen(o_ld_wen),
        .o_ld_be(o_ld_be), .o_ld_data(o_ld_data), .o_ld_boffs(o_ld_boffs), .o_ld_user(o_ld_user),
        .o_ld_lrdy(o_ld_lrdy), .i_ld_r_valid(i_ld_r_valid), .i_ld_r_data(i_ld_r_data),
        .i_ld_r_opc(i_ld_r_opc), .i_ld_r_user(i_ld_r_user),
        .o_st_req(o_st_req), .i_st_gnt(i_st_gnt), .o_st_add(o_st_add), .o_st_wen(o_st_wen),
        .o_st_be(o_st_be), .o_st_data(o_st_data), .o_st_boffs(o_st_boffs), .o_st_user(o_st_user),
        .o_st_lrdy(o_st_lrdy), .i_st_r_valid(i_st_r_valid), .i_st_r_data(i_st_r_data),
        .i_st_r_opc(i_st_r_opc), .i_st_r_user(i_st_r_user),
        .o_outstanding(o_outstanding)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, want, cyc);
    endtask

    // Downstream path model: responses leave each path in order at their due cycle.
    typedef struct { int due; int id; } dn_t;
    dn_t ld_q[$], st_q[$];
    int  order[$];                          // transaction ids in grant order
    logic [DW-1:0] e_data [1024];
    logic          e_opc  [1024];
    logic [UW-1:0] e_user [1024];
    int            e_arr  [1024];           // cycle the response reached the splitter, -1 = not yet
    int  nid = 0, ld_lat = 1, st_lat = 1, last_gnt_cyc = -1;
    bit  lat_rand = 0, gnt_rand = 0, lrdy_rand = 0, ld_hold = 0, st_hold = 0, fix_en = 0, granted = 0;
    logic [DW-1:0] fix_data;
    int  obs_cyc[$];
    logic [DW-1:0] obs_data[$];

    task automatic drive_dn();
        i_ld_r_valid = 1'b0; i_st_r_valid = 1'b0;
        if (!ld_hold && ld_q.size() > 0 && ld_q[0].due <= cyc) begin
            i_ld_r_valid = 1'b1;
            i_ld_r_data = (ld_q[0].id >= 0) ? e_data[ld_q[0].id] : DW'($urandom);
            i_ld_r_opc  = (ld_q[0].id >= 0) ? e_opc[ld_q[0].id] : 1'b1;
            i_ld_r_user = (ld_q[0].id >= 0) ? e_user[ld_q[0].id] : UW'($urandom);
        end
        if (!st_hold && st_q.size() > 0 && st_q[0].due <= cyc) begin
            i_st_r_valid = 1'b1;
            i_st_r_data = (st_q[0].id >= 0) ? e_data[st_q[0].id] : DW'($urandom);
            i_st_r_opc  = (st_q[0].id >= 0) ? e_opc[st_q[0].id] : 1'b1;
            i_st_r_user = (st_q[0].id >= 0) ? e_user[st_q[0].id] : UW'($urandom);
        end
        if (gnt_rand) begin
            i_ld_gnt = ($urandom_range(0, 3) != 0);
            i_st_gnt = ($urandom_range(0, 3) != 0);
        end
        if (lrdy_rand) i_in_lrdy = ($urandom_range(0, 3) != 0);
    endtask

    // Predict outputs from the inputs and scoreboard, then apply this cycle's clock-edge effects.
    task automatic eval_cycle();
        bit full, exp_gnt, exp_rv;
        int h, lat, due;
        full    = (order.size() >= N);
        exp_gnt = i_in_req && !clear_i && !full && (i_in_wen ? i_ld_gnt : i_st_gnt);
        chk("in_gnt", o_in_gnt, exp_gnt);
        chk("ld_req", o_ld_req, i_in_req && i_in_wen && !full && !clear_i);
        chk("st_req", o_st_req, i_in_req && !i_in_wen && !full && !clear_i);
        chk("count", o_outstanding, order.size());
        if (i_in_req && i_in_wen) chk("ld_add", o_ld_add, i_in_add);
        if (i_in_req && !i_in_wen) chk("st_data", o_st_data, i_in_data);
        exp_rv = order.size() > 0 && e_arr[order[0]] >= 0 && e_arr[order[0]] < cyc;
        chk("in_r_valid", o_in_r_valid, exp_rv);
        if (exp_rv) begin
            h = order[0];
            chk("in_r_resp", {o_in_r_data, o_in_r_opc, o_in_r_user}, {e_data[h], e_opc[h], e_user[h]});
        end
        if (o_in_r_valid && i_in_lrdy && !clear_i) begin
            obs_cyc.push_back(cyc);
            obs_data.push_back(o_in_r_data);
        end
        if (clear_i) begin
            order.delete();
            foreach (ld_q[i]) ld_q[i].id = -1;
            foreach (st_q[i]) st_q[i].id = -1;
        end else begin
            if (exp_rv && i_in_lrdy) void'(order.pop_front());
            if (exp_gnt) begin
                h = nid++;
                order.push_back(h);
                e_arr[h]  = -1;
                e_data[h] = fix_en ? fix_data : DW'($urandom);
                e_opc[h]  = 1'($urandom_range(0, 1));
                e_user[h] = UW'($urandom);
                lat = lat_rand ? int'($urandom_range(1, 6)) : (i_in_wen ? ld_lat : st_lat);
                due = cyc + lat;
                if (i_in_wen) begin
                    if (ld_q.size() > 0 && ld_q[$].due >= due) due = ld_q[$].due + 1;
                    ld_q.push_back('{due, h});
                end else begin
                    if (st_q.size() > 0 && st_q[$].due >= due) due = st_q[$].due + 1;
                    st_q.push_back('{due, h});
                end
                granted = 1;
                last_gnt_cyc = cyc;
            end
        end
        if (i_ld_r_valid) begin
            dn_t e;
            e = ld_q.pop_front();
            if (e.id >= 0 && !clear_i) e_arr[e.id] = cyc;
        end
        if (i_st_r_valid) begin
            dn_t e;
            e = st_q.pop_front();
            if (e.id >= 0 && !clear_i) e_arr[e.id] = cyc;
        end
    endtask

    task automatic cycle();
        @(negedge clk_i);
        eval_cycle();
        @(posedge clk_i);
        #1;
        cyc++;
        drive_dn();
    endtask

    task automatic issue(input bit wen, input logic [AW-1:0] add);
        i_in_req = 1'b1; i_in_wen = wen; i_in_add = add;
        i_in_data = DW'($urandom); i_in_be = BEW'($urandom);
        i_in_boffs = BOW'($urandom); i_in_user = UW'($urandom);
        granted = 0;
        for (int k = 0; k < 100 && !granted; k++) cycle();
        chk("issue_granted", granted, 1);
        i_in_req = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((order.size() > 0 || ld_q.size() > 0 || st_q.size() > 0) && k < 300) begin
            cycle();
            k++;
        end
        chk("drained", (order.size() == 0 && ld_q.size() == 0 && st_q.size() == 0), 1);
    endtask

    task automatic wait_rvalid(input string tag);
        for (int k = 0; k < 30 && !o_in_r_valid; k++) cycle();
        chk(tag, o_in_r_valid, 1);
    endtask

    initial begin
        int s_id;
        i_in_req = 0; i_in_wen = 0; i_in_add = '0; i_in_be = '0; i_in_data = '0;
        i_in_boffs = '0; i_in_user = '0; i_in_lrdy = 1;
        i_ld_gnt = 1; i_st_gnt = 1;
        i_ld_r_valid = 0; i_ld_r_data = '0; i_ld_r_opc = 0; i_ld_r_user = '0;
        i_st_r_valid = 0; i_st_r_data = '0; i_st_r_opc = 0; i_st_r_user = '0;
        fix_data = '0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_gnt", o_in_gnt, 0);
        chk("rst_r_valid", o_in_r_valid, 0);
        chk("rst_r_data", o_in_r_data, 0);
        chk("rst_ld_req", o_ld_req, 0);
        chk("rst_st_req", o_st_req, 0);
        chk("rst_count", o_outstanding, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cyc = 0;
        drive_dn();

        // 1: single read, load latency 2 -> upstream response 3 cycles after grant
        ld_lat = 2; fix_en = 1; fix_data = 32'hCAFE; obs_cyc.delete(); obs_data.delete();
        issue(1, 32'h10);
        fix_en = 0;
        drain();
        chk("t1_latency", (obs_cyc.size() > 0) ? obs_cyc[0] - last_gnt_cyc : -1, 3);
        chk("t1_data", (obs_data.size() > 0) ? obs_data[0] : '0, 32'hCAFE);

        // 2: slow write then fast read; store response must come out first
        st_lat = 5; ld_lat = 1; s_id = nid; obs_cyc.delete(); obs_data.delete();
        issue(0, 32'h20);
        issue(1, 32'h24);
        drain();
        chk("t2_first", (obs_data.size() == 2) ? obs_data[0] : '0, e_data[s_id]);
        chk("t2_second", (obs_data.size() == 2) ? obs_data[1] : '0, e_data[s_id + 1]);
        chk("t2_back2back", (obs_cyc.size() == 2) ? obs_cyc[1] - obs_cyc[0] : -1, 1);

        // 3: four reads with responses held -> fifth blocked until the first pop
        ld_hold = 1;
        for (int i = 0; i < N; i++) issue(1, 32'h100 + 32'(i * 4));
        i_in_req = 1; i_in_wen = 1; i_in_add = 32'h200;
        cycle();
        chk("t3_full_gnt", o_in_gnt, 0);
        chk("t3_full_ld_req", o_ld_req, 0);
        obs_cyc.delete(); obs_data.delete();
        ld_hold = 0;
        issue(1, 32'h200);
        chk("t3_resume", (obs_cyc.size() > 0) ? last_gnt_cyc - obs_cyc[0] : -1, 1);
        drain();

        // 4: upstream back-pressure holds the response
        i_in_lrdy = 0; s_id = nid;
        issue(1, 32'h300);
        wait_rvalid("t4_rvalid_up");
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_hold_valid", o_in_r_valid, 1);
            chk("t4_hold_data", o_in_r_data, e_data[s_id]);
            chk("t4_hold_count", o_outstanding, 1);
        end
        i_in_lrdy = 1;
        drain();

        // 5: simultaneous grant and pop at count 3, then random mix
        ld_hold = 1;
        for (int i = 0; i < 3; i++) issue(1, 32'h400 + 32'(i * 4));
        i_in_lrdy = 0; ld_hold = 0;
        wait_rvalid("t5_rvalid_up");
        obs_cyc.delete(); obs_data.delete();
        i_in_req = 1; i_in_wen = 1; i_in_add = 32'h410; i_in_lrdy = 1;
        cycle();
        i_in_req = 0;
        chk("t5_same_cycle", (obs_cyc.size() > 0) ? obs_cyc[0] - last_gnt_cyc : -1, 0);
        chk("t5_count", o_outstanding, 3);
        drain();
        lat_rand = 1; gnt_rand = 1; lrdy_rand = 1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) cycle();
            issue(1'($urandom_range(0, 1)), AW'($urandom));
        end
        lat_rand = 0; gnt_rand = 0; lrdy_rand = 0;
        i_ld_gnt = 1; i_st_gnt = 1; i_in_lrdy = 1;
        drain();

        // 6: clear with two reads in flight; their late responses are swallowed
        ld_lat = 1; ld_hold = 1;
        issue(1, 32'h500);
        issue(1, 32'h504);
        clear_i = 1;
        cycle();
        clear_i = 0;
        chk("t6_count", o_outstanding, 0);
        chk("t6_rvalid", o_in_r_valid, 0);
        ld_hold = 0; s_id = nid; obs_cyc.delete(); obs_data.delete();
        issue(1, 32'h600);
        drain();
        chk("t6_new_only", obs_data.size(), 1);
        chk("t6_new_data", (obs_data.size() > 0) ? obs_data[0] : '0, e_data[s_id]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
